// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch sequencer.
// Turns the run button into start/pause/resume and clr into clear. Divides
// m_clk down to a 10 ms tick and keeps a 4-digit BCD count (SS.hh, 00.00 to
// 99.99 s) that feeds the display driver digits.
// Optional lap/freeze display: define SW_LAP_EN. Without it, lap is unused and
// the digit outputs always show the live count.
module sw_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int LOCK_CYC = 1000000
) (
  input  logic       m_clk,
  input  logic       m_rst,
  input  logic       run,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       m_sec,
  output logic       running,
  output logic       ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t state;

  // Synchronizer and edge-detector stages for the asynchronous buttons.
  logic run_s1, run_s2, run_s3, run_edge;
  logic clr_s1, clr_s2;

  logic [LW-1:0] lock_cnt;
  logic [PW-1:0] pre;
  logic [3:0]    cnt0, cnt1, cnt2, cnt3;

  logic tick;
  logic clear_now;
  logic accept;
  logic c0, c1, c2, c3;

  // Two-flop synchronizers; the run edge is registered so a press seen at
  // edge N moves the FSM at edge N+3.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      run_s1   <= 1'b0;
      run_s2   <= 1'b0;
      run_s3   <= 1'b0;
      run_edge <= 1'b0;
      clr_s1   <= 1'b0;
      clr_s2   <= 1'b0;
    end else begin
      run_s1   <= run;
      run_s2   <= run_s1;
      run_s3   <= run_s2;
      run_edge <= run_s2 & ~run_s3;
      clr_s1   <= clr;
      clr_s2   <= clr_s1;
    end
  end

  // Decode this cycle's tick, clear, accepted run edge and BCD carry chain.
  always_comb begin
    tick      = (state == S_RUN) && (pre == PRE_LAST);
    clear_now = (state == S_PAUSE) && clr_s2;
    // clr beats a simultaneous run edge in PAUSE; the discarded edge does not
    // start a lockout window.
    accept    = run_edge && (lock_cnt == '0) && !clear_now;
    c0        = tick && (cnt0 == 4'd9);
    c1        = c0 && (cnt1 == 4'd9);
    c2        = c1 && (cnt2 == 4'd9);
    c3        = c2 && (cnt3 == 4'd9);
  end

  // Debounce lockout: an accepted run edge blocks further edges for
  // LOCK_CYC cycles.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      lock_cnt <= '0;
    end else if (accept) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - LW'(1);
    end
  end

  // IDLE/RUN/PAUSE sequencer with registered running flag.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      state   <= S_IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (clear_now) begin
            state   <= S_IDLE;
            running <= 1'b0;
          end else if (accept) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // 10 ms prescaler: counts only in RUN, holds in PAUSE so a resume finishes
  // the partial tick, zeroed by clear.
  always_ff @(posedge m_clk) begin
    if (m_rst || clear_now) begin
      pre <= '0;
    end else if (state == S_RUN) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  // BCD cascade, sticky overflow and whole-second pulse.
  always_ff @(posedge m_clk) begin
    if (m_rst || clear_now) begin
      cnt0  <= 4'd0;
      cnt1  <= 4'd0;
      cnt2  <= 4'd0;
      cnt3  <= 4'd0;
      ovf   <= 1'b0;
      m_sec <= 1'b0;
    end else begin
      // Suppressed when the same edge leaves RUN, so m_sec never shows in PAUSE.
      m_sec <= c1 && !accept;
      if (tick) begin
        cnt0 <= c0 ? 4'd0 : cnt0 + 4'd1;
      end
      if (c0) begin
        cnt1 <= c1 ? 4'd0 : cnt1 + 4'd1;
      end
      if (c1) begin
        cnt2 <= c2 ? 4'd0 : cnt2 + 4'd1;
      end
      if (c2) begin
        cnt3 <= c3 ? 4'd0 : cnt3 + 4'd1;
      end
      if (c3) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef SW_LAP_EN
  logic        lap_s1, lap_s2, lap_s3, lap_edge;
  logic        frozen;
  logic [15:0] snap;

  // Lap button synchronizer and registered edge detect, same latency as run.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      lap_s1   <= 1'b0;
      lap_s2   <= 1'b0;
      lap_s3   <= 1'b0;
      lap_edge <= 1'b0;
    end else begin
      lap_s1   <= lap;
      lap_s2   <= lap_s1;
      lap_s3   <= lap_s2;
      lap_edge <= lap_s2 & ~lap_s3;
    end
  end

  // Lap freeze: a lap edge in RUN toggles the freeze; entering IDLE releases it.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      frozen <= 1'b0;
      snap   <= '0;
    end else if (clear_now) begin
      frozen <= 1'b0;
    end else if ((state == S_RUN) && lap_edge) begin
      frozen <= ~frozen;
      if (!frozen) begin
        snap <= {cnt3, cnt2, cnt1, cnt0};
      end
    end
  end

  // Display shows the snapshot while frozen, the live count otherwise.
  always_comb begin
    if (frozen) begin
      {digit3, digit2, digit1, digit0} = snap;
    end else begin
      {digit3, digit2, digit1, digit0} = {cnt3, cnt2, cnt1, cnt0};
    end
  end
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign digit0 = cnt0;
  assign digit1 = cnt1;
  assign digit2 = cnt2;
  assign digit3 = cnt3;
`endif

endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: bench for the stopwatch sequencer (TICK_DIV=4, LOCK_CYC=8).
// A cycle-level reference model built from the stopwatch rules (counts in
// hundredths, lockout as a distance in cycles) predicts every output each
// cycle; a table plus hand sequences pin the documented scenarios.
module tb_sw_ctrl;

  localparam int TICK_DIV = 4;
  localparam int LOCK_CYC = 8;
  localparam int W        = 19;

  // ---------------- clock / reset ----------------
  logic       m_clk = 1'b0;
  logic       m_rst = 1'b1;
  logic       run   = 1'b0;
  logic       clr   = 1'b0;
  logic       lap   = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       m_sec, running, ovf;

  always #5 m_clk = ~m_clk;

  sw_ctrl #(.TICK_DIV(TICK_DIV), .LOCK_CYC(LOCK_CYC)) dut (
    .m_clk  (m_clk),
    .m_rst  (m_rst),
    .run    (run),
    .clr    (clr),
    .lap    (lap),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .m_sec  (m_sec),
    .running(running),
    .ovf    (ovf)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int  m_st;      // 0 idle, 1 run, 2 pause
  int  m_count;   // live count in hundredths
  int  m_pre;
  bit  m_ovf, m_msec, m_frz;
  int  m_snap;
  int  rh[5], ch[5], lh[5];
  int  cyc = 0;
  int  last_acc = -100;

  task automatic model_edge();
    int  old_count, disp, new_st;
    bit  edge_ev, clr_ev, lap_ev, acc, tick, clearing;
    cyc++;
    if (m_rst) begin
      m_st = 0; m_count = 0; m_pre = 0; m_ovf = 0; m_msec = 0;
      m_frz = 0; m_snap = 0; last_acc = cyc - LOCK_CYC;
      for (int i = 0; i < 5; i++) begin rh[i] = 0; ch[i] = 0; lh[i] = 0; end
    end else begin
      for (int i = 4; i > 0; i--) begin rh[i] = rh[i-1]; ch[i] = ch[i-1]; lh[i] = lh[i-1]; end
      rh[0] = int'(run); ch[0] = int'(clr); lh[0] = int'(lap);
      // Button pressed before edge N acts at edge N+3; clr level acts at N+2.
      edge_ev  = (rh[3] == 1) && (rh[4] == 0);
      lap_ev   = (lh[3] == 1) && (lh[4] == 0);
      clr_ev   = (ch[2] == 1);
      clearing = (m_st == 2) && clr_ev;
      acc      = edge_ev && (cyc - last_acc >= LOCK_CYC) && !clearing;
      if (acc) last_acc = cyc;
      tick   = (m_st == 1) && (m_pre == TICK_DIV - 1);
      new_st = m_st;
      if (clearing) new_st = 0;
      else if (acc) new_st = (m_st == 1) ? 2 : 1;
      old_count = m_count;
      if (clearing) begin
        m_count = 0; m_pre = 0; m_ovf = 0;
      end else if (m_st == 1) begin
        m_pre = (m_pre + 1) % TICK_DIV;
        if (tick) begin
          m_count = (m_count + 1) % 10000;
          if (m_count == 0) m_ovf = 1;
        end
      end
      m_msec = tick && (old_count % 100 == 99) && (new_st == 1);
`ifdef SW_LAP_EN
      if (clearing) m_frz = 0;
      else if (lap_ev && m_st == 1) begin
        if (!m_frz) m_snap = old_count;
        m_frz = !m_frz;
      end
`else
      m_frz = 0;
      if (lap_ev) m_snap = old_count;
`endif
      m_st = new_st;
    end
    disp = m_frz ? m_snap : m_count;
    exp_q.push_back({4'((disp / 1000) % 10), 4'((disp / 100) % 10), 4'((disp / 10) % 10),
                     4'(disp % 10), m_msec, (m_st == 1), m_ovf});
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_model();
    logic [W-1:0] got, exp;
    got = {digit3, digit2, digit1, digit0, m_sec, running, ovf};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL model_queue cycle %0d: expected queue empty", cyc);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL model cycle %0d: got d=%h%h.%h%h sec=%b run=%b ovf=%b, want d=%h%h.%h%h sec=%b run=%b ovf=%b",
                 cyc, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                 exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic check_cnt(input string name, input logic e_run, input int e_count,
                           input logic e_sec, input logic e_ovf);
    int shown;
    shown = int'(digit3) * 1000 + int'(digit2) * 100 + int'(digit1) * 10 + int'(digit0);
    checks++;
    if (shown !== e_count || running !== e_run || m_sec !== e_sec || ovf !== e_ovf) begin
      errors++;
      $display("FAIL %s: got count=%0d running=%b m_sec=%b ovf=%b, want count=%0d running=%b m_sec=%b ovf=%b",
               name, shown, running, m_sec, ovf, e_count, e_run, e_sec, e_ovf);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge m_clk);
      model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic do_reset();
    m_rst = 1'b1; run = 1'b0; clr = 1'b0; lap = 1'b0;
    steps(3);
    m_rst = 1'b0;
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic run_v;
    logic clr_v;
    int   n;
    logic e_run;
    int   e_count;
    logic e_sec;
    logic e_ovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Edge numbers count from the first edge after reset release.
    tbl[0]  = '{1'b1, 1'b0, 3,   1'b0, 0,   1'b0, 1'b0}; // edges 1-3: press not yet acted on
    tbl[1]  = '{1'b0, 1'b0, 1,   1'b1, 0,   1'b0, 1'b0}; // edge 4: RUN
    tbl[2]  = '{1'b0, 1'b0, 4,   1'b1, 1,   1'b0, 1'b0}; // edge 8: first tick
    tbl[3]  = '{1'b0, 1'b0, 36,  1'b1, 10,  1'b0, 1'b0}; // edge 44: 00.10
    tbl[4]  = '{1'b0, 1'b0, 359, 1'b1, 99,  1'b0, 1'b0}; // edge 403: 00.99
    tbl[5]  = '{1'b0, 1'b0, 1,   1'b1, 100, 1'b1, 1'b0}; // edge 404: 01.00 + m_sec
    tbl[6]  = '{1'b0, 1'b0, 1,   1'b1, 100, 1'b0, 1'b0}; // m_sec lasts one cycle
    tbl[7]  = '{1'b1, 1'b0, 1,   1'b1, 100, 1'b0, 1'b0}; // press at 406
    tbl[8]  = '{1'b0, 1'b0, 1,   1'b1, 100, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1,   1'b1, 101, 1'b0, 1'b0}; // bounce at 408, tick on 408
    tbl[10] = '{1'b0, 1'b0, 6,   1'b0, 101, 1'b0, 1'b0}; // paused at 409, bounce ignored

    do_reset();
    check_cnt("reset", 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run = tbl[i].run_v;
      clr = tbl[i].clr_v;
      steps(tbl[i].n);
      check_cnt($sformatf("table_%0d", i), tbl[i].e_run, tbl[i].e_count, tbl[i].e_sec, tbl[i].e_ovf);
    end

    // Pause at 00.37 with a partial tick, then resume.
    do_reset();
    run = 1'b1; steps(1); run = 1'b0; steps(149);
    run = 1'b1; steps(1); run = 1'b0; steps(3);
    check_cnt("pause_at_37", 1'b0, 37, 1'b0, 1'b0);
    steps(50);
    check_cnt("pause_hold", 1'b0, 37, 1'b0, 1'b0);
    run = 1'b1; steps(1); run = 1'b0; steps(2);
    check_cnt("resume_wait", 1'b0, 37, 1'b0, 1'b0);
    steps(1);
    check_cnt("resume_run", 1'b1, 37, 1'b0, 1'b0);
    steps(2);
    check_cnt("resume_partial_tick", 1'b1, 38, 1'b0, 1'b0);

    // Wrap past 99.99, then pause and clear.
    do_reset();
    run = 1'b1; steps(1); run = 1'b0; steps(39999);
    check_cnt("pre_wrap", 1'b1, 9999, 1'b0, 1'b0);
    steps(4);
    check_cnt("wrap", 1'b1, 0, 1'b1, 1'b1);
    run = 1'b1; steps(1); run = 1'b0; steps(3);
    check_cnt("wrap_pause", 1'b0, 1, 1'b0, 1'b1);
    clr = 1'b1; steps(3); clr = 1'b0;
    check_cnt("wrap_clear", 1'b0, 0, 1'b0, 1'b0);

    // clr ignored in RUN, clr beats run edge in PAUSE, reset mid-RUN.
    do_reset();
    run = 1'b1; steps(1); run = 1'b0; steps(19);
    clr = 1'b1; steps(5);
    check_cnt("clr_in_run", 1'b1, 5, 1'b0, 1'b0);
    clr = 1'b0; steps(3);
    check_cnt("clr_in_run_after", 1'b1, 6, 1'b0, 1'b0);
    run = 1'b1; steps(1); run = 1'b0; steps(3);
    check_cnt("clr_seq_pause", 1'b0, 7, 1'b0, 1'b0);
    steps(8);
    run = 1'b1; steps(1);
    run = 1'b0; clr = 1'b1; steps(1);
    clr = 1'b0; steps(2);
    check_cnt("clr_beats_run", 1'b0, 0, 1'b0, 1'b0);
    steps(10);
    check_cnt("clr_stays_idle", 1'b0, 0, 1'b0, 1'b0);
    run = 1'b1; steps(1); run = 1'b0; steps(3);
    check_cnt("start_after_clear", 1'b1, 0, 1'b0, 1'b0);
    steps(20);
    check_cnt("run_before_reset", 1'b1, 5, 1'b0, 1'b0);
    m_rst = 1'b1; steps(1); m_rst = 1'b0;
    check_cnt("mid_run_reset", 1'b0, 0, 1'b0, 1'b0);

`ifdef SW_LAP_EN
    // Lap freeze at 00.25, release after the live count passes 00.40.
    do_reset();
    run = 1'b1; steps(1); run = 1'b0; steps(100);
    lap = 1'b1; steps(1); lap = 1'b0; steps(2);
    check_cnt("lap_before", 1'b1, 25, 1'b0, 1'b0);
    steps(60);
    check_cnt("lap_frozen", 1'b1, 25, 1'b0, 1'b0);
    lap = 1'b1; steps(1); lap = 1'b0; steps(2);
    check_cnt("lap_still_frozen", 1'b1, 25, 1'b0, 1'b0);
    steps(1);
    check_cnt("lap_release", 1'b1, 41, 1'b0, 1'b0);
`endif

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      m_rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 4) == 0) run = ~run;
      clr = ($urandom_range(0, 15) == 0);
      lap = ($urandom_range(0, 7) == 0);
      steps(1);
    end
    m_rst = 1'b0;

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
